insn_fetch: RTL and testbench

INSN_FETCH -- requirements
Module: insn_fetch

---
 rtl/insn_fetch_pkg.sv | 19 +
 rtl/insn_fetch_if.sv | 29 ++
 rtl/insn_fetch_skid.sv | 56 +++++
 rtl/insn_fetch.sv | 153 +++++++++++++++
 tb/tb_insn_fetch.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/insn_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit (package fetch_pkg).
package fetch_pkg;

    localparam int INSN_WIDTH = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    // Saturating increment used by the optional performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/insn_fetch_if.sv
// Fetch-unit bus: instruction memory handshake plus the decode-side hand-off.
interface insn_fetch_if #(parameter int PC_WIDTH = 12);
    import fetch_pkg::*;

    logic                  imem_req;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic                  imem_ready;
    logic [INSN_WIDTH-1:0] imem_data;
    logic                  stall;
    logic                  redirect;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic [INSN_WIDTH-1:0] insn;
    logic [PC_WIDTH-1:0]   insn_pc;
    logic                  insn_valid;
    logic [4:0]            opcode;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr, insn, insn_pc, insn_valid, opcode,
        input  imem_ready, imem_data, stall, redirect, redirect_pc
    );

    // Memory / decode environment side.
    modport slave (
        input  imem_req, imem_addr, insn, insn_pc, insn_valid, opcode,
        output imem_ready, imem_data, stall, redirect, redirect_pc
    );

endinterface

// File: rtl/insn_fetch_skid.sv
// One-entry skid buffer holding a fetched word and its pc while decode stalls.
module fetch_skid
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  unload,
    input  logic                  flush,
    input  logic [INSN_WIDTH-1:0] load_data,
    input  logic [PC_WIDTH-1:0]   load_pc,
    output logic [INSN_WIDTH-1:0] data,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  full
);

    logic [INSN_WIDTH-1:0] data_q, data_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  full_q, full_d;

    // Next entry contents: flush beats load, load beats unload.
    always_comb begin
        data_d = data_q;
        pc_d   = pc_q;
        full_d = full_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (load) begin
            data_d = load_data;
            pc_d   = load_pc;
            full_d = 1'b1;
        end else if (unload) begin
            full_d = 1'b0;
        end
    end

    // Entry register.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
            pc_q   <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            pc_q   <= pc_d;
            full_q <= full_d;
        end
    end

    assign data = data_q;
    assign pc   = pc_q;
    assign full = full_q;

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch unit: requests words from imem, registers them for decode,
// absorbs one in-flight word in a skid buffer on stall, flushes on redirect.
// Optional macro INSN_FETCH_PERF_EN adds fetch_count / stall_count outputs.
//
// state | meaning
// IDLE  | one cycle after reset, no request
// REQ   | imem_req high, accepting responses at pc
// HOLD  | skid holds a word, waiting for decode to release the stall
module insn_fetch
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = 12,
    parameter int RESET_PC = 0
) (
    input  logic       clock,
    input  logic       reset,
    insn_fetch_if.master bus
`ifdef INSN_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    fetch_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [INSN_WIDTH-1:0] insn_q, insn_d;
    logic [PC_WIDTH-1:0]   insn_pc_q, insn_pc_d;
    logic                  insn_valid_q, insn_valid_d;

    logic                  skid_load, skid_unload, skid_flush;
    logic [INSN_WIDTH-1:0] skid_data;
    logic [PC_WIDTH-1:0]   skid_pc;
    logic                  skid_full;
    logic                  insn_loaded;

    fetch_skid #(.PC_WIDTH(PC_WIDTH)) u_skid (
        .clock     (clock),
        .reset     (reset),
        .load      (skid_load),
        .unload    (skid_unload),
        .flush     (skid_flush),
        .load_data (bus.imem_data),
        .load_pc   (pc_q),
        .data      (skid_data),
        .pc        (skid_pc),
        .full      (skid_full)
    );

    // Next-state and datapath control; redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        insn_d       = insn_q;
        insn_pc_d    = insn_pc_q;
        insn_valid_d = insn_valid_q;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_flush   = 1'b0;
        insn_loaded  = 1'b0;
        if (bus.redirect) begin
            pc_d         = bus.redirect_pc;
            insn_valid_d = 1'b0;
            skid_flush   = 1'b1;
            state_d      = REQ;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = REQ;
                    if (!bus.stall) insn_valid_d = 1'b0;
                end
                REQ: begin
                    if (bus.imem_ready && (!insn_valid_q || !bus.stall)) begin
                        insn_d       = bus.imem_data;
                        insn_pc_d    = pc_q;
                        insn_valid_d = 1'b1;
                        pc_d         = pc_q + PC_WIDTH'(1);
                        insn_loaded  = 1'b1;
                    end else if (bus.imem_ready) begin
                        skid_load = 1'b1;
                        pc_d      = pc_q + PC_WIDTH'(1);
                        state_d   = HOLD;
                    end else if (!bus.stall) begin
                        insn_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!bus.stall && skid_full) begin
                        insn_d       = skid_data;
                        insn_pc_d    = skid_pc;
                        insn_valid_d = 1'b1;
                        skid_unload  = 1'b1;
                        insn_loaded  = 1'b1;
                        state_d      = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= PC_WIDTH'(RESET_PC);
            insn_q       <= '0;
            insn_pc_q    <= '0;
            insn_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            insn_q       <= insn_d;
            insn_pc_q    <= insn_pc_d;
            insn_valid_q <= insn_valid_d;
        end
    end

    assign bus.imem_req   = (state_q == REQ);
    assign bus.imem_addr  = pc_q;
    assign bus.insn       = insn_q;
    assign bus.insn_pc    = insn_pc_q;
    assign bus.insn_valid = insn_valid_q;
    assign bus.opcode     = insn_q[OPCODE_MSB:OPCODE_LSB];

`ifdef INSN_FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Saturating event counters; only reset clears them.
    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (insn_loaded) fetch_count_d = sat_inc32(fetch_count_q);
        if (bus.stall && insn_valid_q) stall_count_d = sat_inc32(stall_count_q);
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_insn_fetch.sv
// Bench for insn_fetch: directed vector table, random run against a
// behavioural model, PC_WIDTH=4 wrap check, optional perf counter check.
module tb_insn_fetch;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    insn_fetch_if #(.PC_WIDTH(12)) fi ();
    insn_fetch_if #(.PC_WIDTH(4))  fi4 ();

`ifdef INSN_FETCH_PERF_EN
    logic [31:0] fetch_count, stall_count, fetch_count4, stall_count4;
`endif

    insn_fetch #(.PC_WIDTH(12), .RESET_PC(0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (fi.master)
`ifdef INSN_FETCH_PERF_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    insn_fetch #(.PC_WIDTH(4), .RESET_PC(0)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (fi4.master)
`ifdef INSN_FETCH_PERF_EN
        ,
        .fetch_count (fetch_count4),
        .stall_count (stall_count4)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: fetch stream with a queue for words caught by a stall.
    logic [11:0] m_pc;
    logic        m_started;
    logic        m_valid;
    logic [31:0] m_insn;
    logic [11:0] m_ipc;
    logic [31:0] sk_data[$];
    logic [11:0] sk_pc[$];

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endfunction

    task automatic step();
        logic r, rdy, stl, rdr;
        logic [11:0] rpc;
        logic [31:0] dat;
        logic e_req;
        @(posedge clock);
        r = reset; rdy = fi.imem_ready; stl = fi.stall; rdr = fi.redirect;
        rpc = fi.redirect_pc; dat = fi.imem_data;
        #1;
        if (r) begin
            m_pc = 12'd0; m_started = 1'b0; m_valid = 1'b0;
            m_insn = 32'd0; m_ipc = 12'd0;
            sk_data.delete(); sk_pc.delete();
        end else if (rdr) begin
            m_pc = rpc; m_valid = 1'b0; m_started = 1'b1;
            sk_data.delete(); sk_pc.delete();
        end else if (!m_started) begin
            m_started = 1'b1;
            if (!stl) m_valid = 1'b0;
        end else if (sk_data.size() > 0) begin
            if (!stl) begin
                m_insn = sk_data.pop_front();
                m_ipc  = sk_pc.pop_front();
                m_valid = 1'b1;
            end
        end else if (rdy && (!m_valid || !stl)) begin
            m_insn = dat; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 12'd1;
        end else if (rdy) begin
            sk_data.push_back(dat); sk_pc.push_back(m_pc); m_pc = m_pc + 12'd1;
        end else if (!stl) begin
            m_valid = 1'b0;
        end
        e_req = m_started && (sk_data.size() == 0);
        total++;
        if (fi.imem_req !== e_req || fi.imem_addr !== m_pc || fi.insn_valid !== m_valid ||
            fi.insn !== m_insn || fi.insn_pc !== m_ipc || fi.opcode !== m_insn[31:27]) begin
            bad++;
            $display("FAIL model t=%0t: got req=%0d addr=%h v=%0d insn=%h ipc=%h op=%h want req=%0d addr=%h v=%0d insn=%h ipc=%h op=%h",
                     $time, fi.imem_req, fi.imem_addr, fi.insn_valid, fi.insn, fi.insn_pc, fi.opcode,
                     e_req, m_pc, m_valid, m_insn, m_ipc, m_insn[31:27]);
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        stl;
        logic        rdr;
        logic [11:0] rpc;
        logic [31:0] data;
        logic        e_req;
        logic [11:0] e_addr;
        logic        e_valid;
        logic [11:0] e_ipc;
        logic [31:0] e_insn;
    } vec_t;

    vec_t vec[14];

    initial begin
        // rdy stl rdr rpc data | req addr valid ipc insn
        vec[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 32'hDEAD0000, 1'b1, 12'h000, 1'b0, 12'h000, 32'h00000000};
        vec[1]  = '{1'b1, 1'b0, 1'b0, 12'h000, 32'h08000000, 1'b1, 12'h001, 1'b1, 12'h000, 32'h08000000};
        vec[2]  = '{1'b1, 1'b0, 1'b0, 12'h000, 32'h11111111, 1'b1, 12'h002, 1'b1, 12'h001, 32'h11111111};
        vec[3]  = '{1'b1, 1'b1, 1'b0, 12'h000, 32'h22222222, 1'b0, 12'h003, 1'b1, 12'h001, 32'h11111111};
        vec[4]  = '{1'b1, 1'b1, 1'b0, 12'h000, 32'h33333333, 1'b0, 12'h003, 1'b1, 12'h001, 32'h11111111};
        vec[5]  = '{1'b1, 1'b1, 1'b0, 12'h000, 32'h33333333, 1'b0, 12'h003, 1'b1, 12'h001, 32'h11111111};
        vec[6]  = '{1'b1, 1'b0, 1'b0, 12'h000, 32'h44444444, 1'b1, 12'h003, 1'b1, 12'h002, 32'h22222222};
        vec[7]  = '{1'b1, 1'b0, 1'b0, 12'h000, 32'h55555555, 1'b1, 12'h004, 1'b1, 12'h003, 32'h55555555};
        vec[8]  = '{1'b0, 1'b0, 1'b0, 12'h000, 32'h00000000, 1'b1, 12'h004, 1'b0, 12'h003, 32'h55555555};
        vec[9]  = '{1'b1, 1'b1, 1'b0, 12'h000, 32'h66666666, 1'b1, 12'h005, 1'b1, 12'h004, 32'h66666666};
        vec[10] = '{1'b1, 1'b1, 1'b0, 12'h000, 32'h77777777, 1'b0, 12'h006, 1'b1, 12'h004, 32'h66666666};
        vec[11] = '{1'b1, 1'b1, 1'b1, 12'h040, 32'hABABABAB, 1'b1, 12'h040, 1'b0, 12'h004, 32'h66666666};
        vec[12] = '{1'b1, 1'b0, 1'b0, 12'h000, 32'h88888888, 1'b1, 12'h041, 1'b1, 12'h040, 32'h88888888};
        vec[13] = '{1'b1, 1'b0, 1'b1, 12'h010, 32'h99999999, 1'b1, 12'h010, 1'b0, 12'h040, 32'h88888888};

        reset = 1'b1;
        fi.imem_ready = 1'b0; fi.imem_data = '0; fi.stall = 1'b0;
        fi.redirect = 1'b0; fi.redirect_pc = '0;
        fi4.imem_ready = 1'b0; fi4.imem_data = '0; fi4.stall = 1'b0;
        fi4.redirect = 1'b0; fi4.redirect_pc = '0;
        step(); step();
        chk("rst_req",   32'(fi.imem_req),   32'd0);
        chk("rst_addr",  32'(fi.imem_addr),  32'd0);
        chk("rst_valid", 32'(fi.insn_valid), 32'd0);
        chk("rst_insn",  fi.insn,            32'd0);
        chk("rst_op",    32'(fi.opcode),     32'd0);

        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            fi.imem_ready = vec[i].rdy; fi.stall = vec[i].stl; fi.redirect = vec[i].rdr;
            fi.redirect_pc = vec[i].rpc; fi.imem_data = vec[i].data;
            step();
            chk($sformatf("vec%0d_req", i),   32'(fi.imem_req),   32'(vec[i].e_req));
            chk($sformatf("vec%0d_addr", i),  32'(fi.imem_addr),  32'(vec[i].e_addr));
            chk($sformatf("vec%0d_valid", i), 32'(fi.insn_valid), 32'(vec[i].e_valid));
            chk($sformatf("vec%0d_ipc", i),   32'(fi.insn_pc),    32'(vec[i].e_ipc));
            chk($sformatf("vec%0d_insn", i),  fi.insn,            vec[i].e_insn);
            if (i == 1) chk("opcode_0x08000000", 32'(fi.opcode), 32'd1);
        end

        // Reset while a request is outstanding: response must be dropped.
        fi.redirect = 1'b0; fi.stall = 1'b0; fi.imem_ready = 1'b1; fi.imem_data = 32'hAAAAAAAA;
        reset = 1'b1;
        step();
        chk("rst_mid_valid", 32'(fi.insn_valid), 32'd0);
        chk("rst_mid_insn",  fi.insn,            32'd0);
        chk("rst_mid_req",   32'(fi.imem_req),   32'd0);
        reset = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(0, 199) == 0);
            fi.imem_ready  = ($urandom_range(0, 3) != 0);
            fi.stall       = ($urandom_range(0, 2) == 0);
            fi.redirect    = ($urandom_range(0, 29) == 0);
            fi.redirect_pc = 12'($urandom);
            fi.imem_data   = $urandom;
            step();
        end

        // PC_WIDTH=4 instance: increment wraps 15 -> 0.
        reset = 1'b0; fi.imem_ready = 1'b0; fi.stall = 1'b0; fi.redirect = 1'b0;
        fi4.redirect = 1'b1; fi4.redirect_pc = 4'd14;
        step();
        chk("w4_addr14", 32'(fi4.imem_addr), 32'd14);
        fi4.redirect = 1'b0; fi4.imem_ready = 1'b1; fi4.imem_data = 32'h0000000E;
        step();
        chk("w4_addr15", 32'(fi4.imem_addr), 32'd15);
        fi4.imem_data = 32'h0000000F;
        step();
        chk("w4_wrap_addr", 32'(fi4.imem_addr), 32'd0);
        chk("w4_wrap_ipc",  32'(fi4.insn_pc),   32'd15);
        step();
        chk("w4_after_ipc", 32'(fi4.insn_pc),   32'd0);
        fi4.imem_ready = 1'b0;

`ifdef INSN_FETCH_PERF_EN
        reset = 1'b1; step();
        reset = 1'b0; fi.imem_ready = 1'b1; fi.stall = 1'b0;
        step();
        for (int k = 0; k < 10; k++) begin
            fi.imem_data = 32'(k);
            step();
        end
        fi.imem_ready = 1'b0; fi.stall = 1'b1;
        for (int k = 0; k < 4; k++) step();
        fi.stall = 1'b0;
        step();
        chk("perf_fetch", fetch_count, 32'd10);
        chk("perf_stall", stall_count, 32'd4);
        fi.imem_ready = 1'b1;
        step();
        force dut.stall_count_q = 32'hFFFFFFFF;
        #1;
        release dut.stall_count_q;
        fi.imem_ready = 1'b0; fi.stall = 1'b1;
        step(); step();
        chk("perf_stall_sat", stall_count, 32'hFFFFFFFF);
        fi.stall = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
